// File: rtl/alu_exec_if.sv
// Handshake bundle between the execute-stage ALU and its neighbours:
// an operation/operand request channel and a result/flags response channel.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, aluctl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, aluctl, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, iterative shift-add MUL,
// registered result with zero/overflow flags over a valid/ready handshake.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;
  localparam logic [3:0] OP_XOR = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {overflow, result} for every single-cycle opcode.
  function automatic logic [WIDTH:0] alu_op(input logic [3:0]       ctl,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    logic             o;
    r = '0;
    o = 1'b0;
    case (ctl)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_ADD: begin
        r = x + y;
        o = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        r = x - y;
        o = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_NOR: r = ~(x | y);
      OP_XOR: r = x ^ y;
      default: begin
        r = '0;
        o = 1'b0;
      end
    endcase
    return {o, r};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH:0]   op_res_s;
  logic [WIDTH-1:0] mul_sum_s;

  // Next-state, handshake and datapath decode.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE:    in_ready_s = 1'b1;
      MUL:     in_ready_s = 1'b0;
      DONE:    in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase

    accept_s  = bus.in_valid && in_ready_s;
    op_res_s  = alu_op(bus.aluctl, bus.a, bus.b);
    mul_sum_s = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          if (bus.aluctl == OP_MUL) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            state_d  = MUL;
          end else begin
            result_d = op_res_s[WIDTH-1:0];
            zero_d   = (op_res_s[WIDTH-1:0] == '0);
            ovf_d    = op_res_s[WIDTH];
            state_d  = DONE;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      MUL: begin
        acc_d    = mul_sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = mul_sum_s;
          zero_d   = (mul_sum_s == '0);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          state_d  = MUL;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed ops push expected results, a negedge
// monitor pops and compares on every output transfer.
module tb_alu_exec;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;
  localparam logic [3:0] OP_XOR = 4'd13;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
  } exp_t;

  logic clk;
  logic rst;
  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   send_waits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op and hold it until accepted; optionally queue its expected output.
  task automatic send(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] er, input logic ez, input logic eo, input bit push);
    bit   accepted;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.aluctl   = ctl;
    bus.a        = av;
    bus.b        = bv;
    if (push) begin
      e.res = er;
      e.z   = ez;
      e.o   = eo;
      sb_q.push_back(e);
    end
    accepted   = 1'b0;
    send_waits = 0;
    while (!accepted && send_waits < 200) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
      send_waits++;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", ctl);
    end
  endtask

  // Monitor: every negedge with out_valid&&out_ready is one transfer at the next edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h with empty scoreboard", bus.result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_result", 64'(bus.result), 64'(e.res));
        chk("sb_zero", 64'(bus.zero), 64'(e.z));
        chk("sb_overflow", 64'(bus.overflow), 64'(e.o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    bit done;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.aluctl    = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // ADD overflow, valid right after the accepting edge
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    chk("add_latency", 64'(bus.out_valid), 64'd1);
    send(OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
    send(OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);

    // MUL: out_valid first sampled high at edge WIDTH+1 after accept
    send(OP_MUL, 32'h0001_0003, 32'd7, 32'h0007_0015, 1'b0, 1'b0, 1'b1);
    k    = 0;
    bad  = 0;
    done = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.out_valid === 1'b1) begin
        done         = 1'b1;
        bus.in_valid = 1'b0;
      end else begin
        if (bus.in_ready !== 1'b0) bad++;
        bus.in_valid = k[0];
        bus.aluctl   = OP_ADD;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;
      end
    end
    chk("mul_latency", 64'(k), 64'(W + 1));
    chk("mul_in_ready_low", 64'(bad), 64'd0);
    @(posedge clk);
    #1;

    // MUL wrap boundary, then an op that must wait behind it
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b1);
    chk("and_waits_behind_mul", 64'(send_waits >= W), 64'd1);

    // Stall after XOR: outputs hold, in_ready follows out_ready
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'hF00F_F00F ||
          bus.zero !== 1'b0 || bus.overflow !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    chk("stall_hold", 64'(bad), 64'd0);
    bus.out_ready = 1'b1;
    send(OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
    chk("stream_0", 64'(send_waits), 64'd1);
    send(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    chk("stream_1", 64'(send_waits), 64'd1);
    send(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    chk("stream_2", 64'(send_waits), 64'd1);
    send(OP_OR, 32'h0000_00A0, 32'h0000_000B, 32'h0000_00AB, 1'b0, 1'b0, 1'b1);
    chk("stream_3", 64'(send_waits), 64'd1);
    @(posedge clk);
    #1;

    // Reset during a MUL abandons it
    send(OP_MUL, 32'h0000_1234, 32'h0000_0056, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mulrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mulrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mulrst_result", 64'(bus.result), 64'd0);
    bad = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    chk("mulrst_abandoned", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    send(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);

    // Undefined opcodes and remaining logic ops
    send(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1);
    send(4'd4, 32'd1, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
    send(OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    send(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
